// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and the beat-count helper for the burst data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_1  = 2'b00,
    SZ_4  = 2'b01,
    SZ_8  = 2'b10,
    SZ_16 = 2'b11
  } access_size_e;

  typedef enum logic [1:0] {
    WD_WORD = 2'b00,
    WD_HALF = 2'b01,
    WD_BYTE = 2'b10,
    WD_RSVD = 2'b11
  } width_sel_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WR_BURST = 2'b01,
    RD_BURST = 2'b10
  } state_e;

  function automatic logic [4:0] beats_of(input logic [1:0] size);
    case (size)
      SZ_4:    beats_of = 5'd4;
      SZ_8:    beats_of = 5'd8;
      SZ_16:   beats_of = 5'd16;
      default: beats_of = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-wide storage with one big-endian 4-byte read port and a byte-enabled write port.
module dmem_byte_array #(
  parameter int DEPTH  = 1048576,
  parameter int WIDX_W = $clog2(DEPTH) - 2
) (
  input  logic              clock,
  input  logic [WIDX_W-1:0] rd_word,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [WIDX_W-1:0] wr_word,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be
);

  logic [7:0] mem [DEPTH];

  // Lowest byte address sits in the most significant lane.
  assign rd_data = {mem[{rd_word, 2'd0}], mem[{rd_word, 2'd1}],
                    mem[{rd_word, 2'd2}], mem[{rd_word, 2'd3}]};

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[3-k]) mem[{wr_word, 2'(k)}] <= wr_data[31-8*k -: 8];
      end
    end
  end

endmodule

// File: rtl/burst_data_memory.sv
// Burst-capable big-endian data memory; define DMEM_BURST_WRAP_EN for
// critical-word-first wrapping bursts instead of linear incrementing bursts.
module burst_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1048576,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            access_size,
  input  logic [1:0]            width_sel,
  input  logic                  load_unsigned,
  input  logic                  rw,
  input  logic                  enable,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  error
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int WIDX_W = IDX_W - 2;
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] word,
                                                        input logic [1:0] ws,
                                                        input logic [1:0] lane,
                                                        input logic uns);
    logic [7:0]                   b;
    logic [15:0]                  h;
    logic signed [7:0]            sb;
    logic signed [15:0]           sh;
    logic signed [DATA_WIDTH-1:0] r;
    b  = word[DATA_WIDTH-1-8*int'(lane) -: 8];
    h  = word[DATA_WIDTH-1-8*int'(lane[1]) * 2 -: 16];
    sb = b;
    sh = h;
    case (ws)
      WD_BYTE: if (uns) r = {{(DATA_WIDTH-8){1'b0}}, b};  else r = sb;
      WD_HALF: if (uns) r = {{(DATA_WIDTH-16){1'b0}}, h}; else r = sh;
      default: r = word;
    endcase
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d, n_q;
  logic [ADDR_WIDTH-1:0] base_q;

  logic [4:0]            req_n;
  logic [ADDR_WIDTH-1:0] span_addr, span_off;
  logic [ADDR_WIDTH:0]   span_len;
  logic                  range_err, align_err, rsvd_err, req_err, accept;

  assign req_n = beats_of(access_size);

`ifdef DMEM_BURST_WRAP_EN
  logic [3:0]            start_q, req_start, cur_start;
  logic [ADDR_WIDTH-1:0] blk_mask;
  // Bursts span the 4*N-aligned block containing the request address.
  assign blk_mask  = ADDR_WIDTH'({req_n, 2'b00}) - ADDR_WIDTH'(1);
  assign span_addr = (access_size != SZ_1) ? (address & ~blk_mask) : address;
  assign req_start = address[5:2] & 4'(req_n - 5'd1);
`else
  assign span_addr = address;
`endif

  assign span_off = span_addr - START_ADDR;

  always_comb begin
    span_len = (ADDR_WIDTH+1)'(4);
    if (access_size != SZ_1)         span_len = (ADDR_WIDTH+1)'({req_n, 2'b00});
    else if (width_sel == WD_HALF)   span_len = (ADDR_WIDTH+1)'(2);
    else if (width_sel == WD_BYTE)   span_len = (ADDR_WIDTH+1)'(1);
  end

  // Underflow of the START_ADDR subtraction and overrun past DEPTH are both out of range.
  assign range_err = (span_addr < START_ADDR) || (({1'b0, span_off} + span_len) > DEPTH_X);
  assign align_err = (access_size != SZ_1 || width_sel == WD_WORD) ? (address[1:0] != 2'b00) :
                     (width_sel == WD_HALF) ? address[0] : 1'b0;
  assign rsvd_err  = (access_size == SZ_1) && (width_sel == WD_RSVD);
  assign req_err   = range_err || align_err || rsvd_err;
  assign accept    = (state_q == IDLE) && enable && !req_err;

  logic [ADDR_WIDTH-1:0] cur_base, beat_off;
  logic [4:0]            cur_cnt, cur_n;

  always_comb begin
    cur_base = (state_q == IDLE) ? span_off : base_q;
    cur_cnt  = (state_q == IDLE) ? 5'd0 : cnt_q;
    cur_n    = (state_q == IDLE) ? req_n : n_q;
  end

`ifdef DMEM_BURST_WRAP_EN
  assign cur_start = (state_q == IDLE) ? req_start : start_q;
  assign beat_off  = cur_base +
                     ADDR_WIDTH'({(cur_start + cur_cnt[3:0]) & 4'(cur_n - 5'd1), 2'b00});
`else
  assign beat_off  = cur_base + ADDR_WIDTH'({cur_cnt, 2'b00});
  logic unused_n;
  assign unused_n = ^cur_n;
`endif

  logic [1:0]            lane, eff_ws;
  logic [31:0]           rd_data, wr_data;
  logic [3:0]            wr_be;
  logic                  mem_we, rd_load, err_pulse;
  logic [DATA_WIDTH-1:0] rd_ext;
  logic                  unused_bits;

  assign lane        = beat_off[1:0];
  assign eff_ws      = (state_q == IDLE && access_size == SZ_1) ? width_sel : WD_WORD;
  assign unused_bits = ^beat_off[ADDR_WIDTH-1:IDX_W];

  always_comb begin
    wr_data = data_in;
    wr_be   = 4'b1111;
    if (eff_ws == WD_BYTE) begin
      wr_data = {4{data_in[7:0]}};
      wr_be   = 4'b1000 >> lane;
    end else if (eff_ws == WD_HALF) begin
      wr_data = {2{data_in[15:0]}};
      wr_be   = 4'b1100 >> lane;
    end
  end

  dmem_byte_array #(.DEPTH(DEPTH), .WIDX_W(WIDX_W)) u_array (
    .clock   (clock),
    .rd_word (beat_off[IDX_W-1:2]),
    .rd_data (rd_data),
    .wr_en   (mem_we),
    .wr_word (beat_off[IDX_W-1:2]),
    .wr_data (wr_data),
    .wr_be   (wr_be)
  );

  assign rd_ext = load_extend(rd_data, eff_ws, lane, load_unsigned);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    rd_load   = 1'b0;
    err_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        err_pulse = enable && req_err;
        mem_we    = accept && !rw;
        rd_load   = accept && rw;
        if (accept && req_n != 5'd1) begin
          state_d = rw ? RD_BURST : WR_BURST;
          cnt_d   = 5'd1;
        end
      end
      WR_BURST, RD_BURST: begin
        mem_we  = (state_q == WR_BURST);
        rd_load = (state_q == RD_BURST);
        if (cnt_q == n_q - 5'd1) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      n_q        <= 5'd1;
      data_valid <= 1'b0;
      error      <= 1'b0;
      data_out   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_valid <= rd_load;
      error      <= err_pulse;
      if (accept)  n_q      <= req_n;
      if (rd_load) data_out <= rd_ext;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      base_q <= span_off;
`ifdef DMEM_BURST_WRAP_EN
      start_q <= req_start;
`endif
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: doc/burst_data_memory.md
BURST_DATA_MEMORY -- requirements
Module: burst_data_memory

Interface
REQ-001 Parameter DATA_WIDTH, 32, data bus width in bits; multiple of 8, fixed at 32 in this generation.
REQ-002 Parameter ADDR_WIDTH, 32, byte address width.
REQ-003 Parameter DEPTH, 1048576, storage size in bytes.
REQ-004 Parameter START_ADDR, 32'h80020000, byte address mapped to storage index 0.
REQ-005 clock  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 address  input  ADDR_WIDTH  byte address of first beat, sampled only on accept.
REQ-008 data_in  input  DATA_WIDTH  write data, big-endian (bits 31:24 at lowest byte address).
REQ-009 access_size  input  2  00=1 beat, 01=4, 10=8, 11=16 word beats.
REQ-010 width_sel  input  2  00=word, 01=halfword, 10=byte, 11=reserved (treated as error); applies only when access_size=00.
REQ-011 load_unsigned  input  1  1=zero-extend sub-word reads, 0=sign-extend.
REQ-012 rw  input  1  1=read, 0=write.
REQ-013 enable  input  1  request strobe, sampled in IDLE only.
REQ-014 busy  output  1  high while a burst is in progress (state != IDLE).
REQ-015 data_out  output  DATA_WIDTH  registered read data.
REQ-016 data_valid  output  1  one-cycle-per-beat qualifier for data_out.
REQ-017 error  output  1  one-cycle pulse on a rejected request.

Function
REQ-018 FSM states IDLE, WR_BURST, RD_BURST; beat count N=1/4/8/16 from access_size latched on accept.
REQ-019 Accept = rising edge in IDLE with enable=1 and no error condition; base address, N, rw latched.
REQ-020 Write accept edge stores beat 0 data_in; if N>1 enter WR_BURST with beat counter=1, else stay IDLE.
REQ-021 In WR_BURST each edge stores data_in at beat address, increments counter; on beat N-1 return to IDLE.
REQ-022 Read accept edge loads data_out with beat 0 and sets data_valid=1 (latency 1 cycle); RD_BURST repeats per beat identically.
REQ-023 data_valid is 0 in every cycle not following a read beat edge; data_out holds last value otherwise.
REQ-024 Beat address = base + 4*counter (linear) unless REQ-033 applies.
REQ-025 enable, address, rw, access_size ignored while busy=1; back-to-back request accepted the edge after returning to IDLE.
REQ-026 Sub-word write: byte stores data_in[7:0] at address; halfword stores data_in[15:8] at address, data_in[7:0] at address+1; other bytes untouched.
REQ-027 Sub-word read: byte/halfword placed in data_out low bits, extended per load_unsigned.
REQ-028 Error conditions: any byte of the whole burst outside [START_ADDR, START_ADDR+DEPTH); word/burst address[1:0]!=0; halfword address[0]!=0; width_sel=11.
REQ-029 On error: no storage access, error=1 for one cycle, data_valid=0, data_out unchanged, stay IDLE.
REQ-030 Index arithmetic done at ADDR_WIDTH bits; subtraction of START_ADDR must not wrap silently (underflow counts as out of range).

Reset
REQ-031 Reset forces IDLE, counter=0, busy=0, data_valid=0, error=0, data_out=0, independent of clock.
REQ-032 Reset mid-burst aborts remaining beats; beats already written remain; storage contents never cleared by reset.

Configuration
REQ-033 With DMEM_BURST_WRAP_EN defined: beat address = block_base + ((address offset/4 + counter) mod N)*4, block_base aligned to 4*N bytes (critical-word-first wrap); range check on the aligned block.
REQ-034 Without DMEM_BURST_WRAP_EN: linear incrementing bursts only, per REQ-024.

Structure
REQ-035 Package dmem_pkg holds access_size and width_sel encodings, FSM state enum, and beats-from-access_size function.
REQ-036 Sub-module dmem_byte_array: byte-wide DEPTH array, one 4-byte big-endian read port and write port with per-byte write enables.

Verification
REQ-037 Reset, write word 32'hDEADBEEF at 32'h80020000, read it -> data_out=32'hDEADBEEF, data_valid=1 one cycle after accept.
REQ-038 Write 4-beat burst 1,2,3,4 at 32'h80020010 -> busy=1 for 3 cycles; 4-beat read returns 1,2,3,4 on consecutive cycles.
REQ-039 Store byte 8'h80 at 32'h80020003, read byte with load_unsigned=0 -> 32'hFFFFFF80; with load_unsigned=1 -> 32'h00000080.
REQ-040 Read word at 32'h80020002 and at 32'h7FFFFFFC -> error=1 one cycle, data_valid=0, storage unchanged.
REQ-041 With DMEM_BURST_WRAP_EN, 4-beat read at 32'h80020018 after writing 10,11,12,13 at 32'h80020010 -> returns 12,13,10,11.
REQ-042 Assert reset in cycle 2 of an 8-beat write -> busy=0 immediately, beats 0-1 stored, beats 2-7 not stored.
